// File: rtl/mux_seq_pkg.sv
// Package for the mux_seq_n block.
// Holds the selection-mode enum, the scan FSM state enum and the helper
// that sizes channel-index fields.
// Shared by mux_n_1 and mux_seq_n via import mux_seq_pkg::*.
package mux_seq_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_e;

    typedef enum logic {
        WAIT = 1'b0,
        CAP  = 1'b1
    } scan_state_e;

    // Width of a channel index for n channels (n >= 2).
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_1.sv
// mux_n_1: purely combinational N:1 selector, W bits per channel.
// Ports:
//   din  in  N*W    channel data, channel k at din[k*W +: W]
//   sel  in  SEL_W  channel index
//   dout out W      selected channel, 0 when sel >= N
//   err  out 1      high when sel >= N
module mux_n_1
    import mux_seq_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int W     = 1,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N*W-1:0]   din,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     dout,
    output logic             err
);

    always_comb begin
        dout = '0;
        err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) begin
                dout = din[k*W +: W];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_seq_n.sv
// mux_seq_n: N-channel W-bit multiplexer with a registered valid/ready
// output. Direct mode takes the channel from sel; scan mode walks the
// channels with a programmable dwell between captures.
// Optional feature macro: MUX_SEQ_MASK_EN (adds ch_mask to restrict the scan).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   din        N*W channel data
//   sel        direct-mode channel select
//   mode       0 direct, 1 scan
//   dwell      idle cycles between scan captures
//   out_data   captured data
//   out_ch     channel index of out_data
//   out_err    captured select was >= N
//   out_valid  output register holds an untransferred sample
//   ch_mask    (MUX_SEQ_MASK_EN only) per-channel scan enable
//   out_ready  downstream accepts the sample
module mux_seq_n
    import mux_seq_pkg::*;
#(
    parameter  int N       = 16,
    parameter  int W       = 1,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*W-1:0]     din,
    input  logic [SEL_W-1:0]   sel,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_ch,
    output logic               out_err,
    output logic               out_valid,
`ifdef MUX_SEQ_MASK_EN
    input  logic [N-1:0]       ch_mask,
`endif
    input  logic               out_ready
);

    logic [N-1:0] mask;
`ifdef MUX_SEQ_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    // Next enabled channel after cur in wrap order; cur itself if no other.
    function automatic logic [SEL_W-1:0] next_en(input logic [SEL_W-1:0] cur,
                                                  input logic [N-1:0] m);
        logic [SEL_W-1:0] r;
        int idx;
        r = cur;
        for (int k = N - 1; k >= 1; k--) begin
            idx = (int'(cur) + k) % N;
            if (m[idx]) r = SEL_W'(idx);
        end
        return r;
    endfunction

    // Lowest enabled channel (0 when none is enabled).
    function automatic logic [SEL_W-1:0] first_en(input logic [N-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m[k]) r = SEL_W'(k);
        end
        return r;
    endfunction

    logic               mode_p1;
    scan_state_e        state_p1, state_d;
    logic [SEL_W-1:0]   ch_p1, ch_d;
    logic [DWELL_W-1:0] dc_p1, dc_d;
    logic               free, mode_chg, is_scan, scan_cap, load;
    logic [SEL_W-1:0]   mux_sel;
    logic [W-1:0]       mux_dout;
    logic               mux_err;

    assign free     = !out_valid || out_ready;
    assign mode_chg = (mode != mode_p1);
    assign is_scan  = (mux_mode_e'(mode) == MODE_SCAN);
    assign mux_sel  = is_scan ? ch_p1 : sel;
    // Neither mode captures on the edge that enters scan mode; the first
    // scan capture happens one edge later from the reset channel.
    assign load     = free && (is_scan ? scan_cap : 1'b1);

    mux_n_1 #(.N(N), .W(W)) u_mux (
        .din  (din),
        .sel  (mux_sel),
        .dout (mux_dout),
        .err  (mux_err)
    );

    // Scan FSM next state. The WAIT exit is taken on the cycle dc reaches 0,
    // and dwell == 0 keeps the FSM in CAP, so a channel period is dwell + 1.
    always_comb begin
        state_d  = state_p1;
        ch_d     = ch_p1;
        dc_d     = dc_p1;
        scan_cap = 1'b0;
        if (mode_chg) begin
            ch_d    = first_en(mask);
            dc_d    = '0;
            state_d = CAP;
        end else if (is_scan) begin
            case (state_p1)
                WAIT: begin
                    if (mask != '0) begin
                        if (dc_p1 == '0 || dc_p1 == DWELL_W'(1)) state_d = CAP;
                        if (dc_p1 != '0) dc_d = dc_p1 - DWELL_W'(1);
                    end
                end
                CAP: begin
                    if (mask == '0) begin
                        state_d = WAIT;
                    end else if (free) begin
                        scan_cap = 1'b1;
                        ch_d     = next_en(ch_p1, mask);
                        if (dwell != '0) begin
                            dc_d    = dwell;
                            state_d = WAIT;
                        end
                    end
                end
                default: state_d = CAP;
            endcase
        end
    end

    // Stage p1: control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_p1  <= 1'b0;
            state_p1 <= CAP;
            ch_p1    <= '0;
            dc_p1    <= '0;
        end else begin
            mode_p1  <= mode;
            state_p1 <= state_d;
            ch_p1    <= ch_d;
            dc_p1    <= dc_d;
        end
    end

    // Stage p1: output register; a transfer and a load on the same edge
    // keep out_valid high with the new sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= mux_dout;
            out_ch    <= mux_sel;
            out_err   <= is_scan ? 1'b0 : mux_err;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
